matrix_key_scan: RTL and testbench
==================================

// Module: matrix_key_scan
// PURPOSE
//  Input-side counterpart of the multiplexed 7-seg scan: scans a 4x4 key matrix row by row,
//  debounces a single pressed key and reports a 4-bit key code with a one-cycle valid strobe.
//  Feeds the clock's mode/adjust control logic (model, date_time_ch, adjust values) in place of discrete buttons.
// PARAMETERS
//  SCAN_DIV      1000  clk cycles per row step (>=2); one frame = 4*SCAN_DIV cycles
//  DEBOUNCE_CNT  4     consecutive identical frames required to accept a press or a release (>=1)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  col_in     in   4  matrix columns, active-low (pulled up), asynchronous to clk
//  row_out    out  4  row drive, one-hot active-low
//  key_code   out  4  accepted key = row*4 + col, held until next accepted press
//  key_valid  out  1  one-cycle pulse when a new press is accepted
//  key_held   out  1  high from accepted press until accepted release
// BEHAVIOUR
//  Reset (async): row_out=4'b1110, key_code=0, key_valid=0, key_held=0, counters=0, state=IDLE.
//  - col_in passes through a 2-FF synchronizer (reset value 4'b1111) before any use.
//  - Tick: divider counts 0..SCAN_DIV-1; tick=1 for one cycle when count==SCAN_DIV-1. No derived clocks.
//  - Row scan: row_out rotates 1110->1101->1011->0111->1110, advancing on the cycle after each tick.
//    On each tick, the synchronized columns for the currently driven row are sampled into a 16-bit frame map.
//  - Frame end = tick while row 3 is driven. Frame classification:
//    NONE (no bit set), ONE(code) (exactly one bit), MULTI (>=2 bits; treated as NONE, no code reported).
//  - FSM, evaluated only at frame end; frame counter cnt saturates at DEBOUNCE_CNT:
//    IDLE:     ONE(c) -> cand=c, cnt=1, go DB_PRESS (or accept immediately if DEBOUNCE_CNT==1).
//    DB_PRESS: ONE(cand) -> cnt++; at cnt==DEBOUNCE_CNT accept, go PRESSED.
//              ONE(other) -> cand=other, cnt=1. NONE/MULTI -> IDLE.
//    PRESSED:  ONE(key_code) -> stay. Anything else -> cnt=1, go DB_RELEASE.
//    DB_REL:   ONE(key_code) -> PRESSED (bounce). NONE/MULTI/ONE(other) -> cnt++;
//              at cnt==DEBOUNCE_CNT -> IDLE, key_held=0.
//  - Accept: key_code<=cand, key_held<=1, key_valid=1 in the cycle after the frame-end tick,
//    then 0 the next cycle. Exactly one pulse per press; no auto-repeat.
//  - A second key pressed while one is held is ignored; no new key_valid until a full release completes.
//  - Press latency: key_valid rises 1 cycle after the DEBOUNCE_CNT-th consecutive matching frame end.
//  - Reset mid-operation: everything returns to reset values at once; a key still held after reset
//    is re-debounced from IDLE and reported once.
//  - Widths: divider $clog2(SCAN_DIV) bits, frame counter $clog2(DEBOUNCE_CNT+1) bits, no wrap past limits.
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE, DB_PRESS, PRESSED, DB_REL), ROWS=4, COLS=4,
//    and key-code constants for the mode keys used by the control logic.
//  - Sub-module scan_tick_gen: parameterized enable-pulse divider (SCAN_DIV), reusable
//    by the display scanner; everything else inline.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=3, frame = 16 clk)
//  - Reset: row_out=1110, key_code=0, key_valid=0, key_held=0; rows rotate every 4 clk, in order, wrapping.
//  - Clean press: col_in[2]=0 only while row_out=1101 -> key_code=6, single key_valid pulse
//    1 clk after the 3rd frame end; key_held=1; release for 3 frames -> key_held=0, no pulse.
//  - Bounce: key 6 present 2 frames, absent 1, present 3 -> exactly one key_valid (code 6)
//    after the last 3 frames; release bounce of 1 empty frame in DB_REL -> back to PRESSED, no new pulse.
//  - Multi-key: keys 0 and 15 held together -> no key_valid; release 15 leaving 0 -> code 0 after 3 frames.
//  - Held-key override: hold 6, add 9 -> no pulse; release both, then press 9 -> code 9.
//  - Async reset asserted mid-DB_PRESS with key held -> outputs reset immediately; after deassert,
//    key reported once after 3 frames.

Source files
------------

// File: rtl/matrix_key_scan_pkg.sv
// matrix_key_scan_pkg
//   Shared definitions for the 4x4 key matrix scanner: matrix geometry,
//   debounce FSM state encoding, frame classification types, key-code
//   constants for the clock's mode/adjust keys and a frame classifier.
package matrix_key_scan_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    PRESSED  = 2'd2,
    DB_REL   = 2'd3
  } scan_state_t;

  typedef enum logic [1:0] {
    FRAME_NONE  = 2'd0,
    FRAME_ONE   = 2'd1,
    FRAME_MULTI = 2'd2
  } frame_kind_t;

  typedef struct packed {
    frame_kind_t kind;
    logic [3:0]  code;
  } frame_class_t;

  // Keys wired to the clock's mode / date-time / adjust control logic
  localparam logic [3:0] KEY_MODE      = 4'd12;
  localparam logic [3:0] KEY_DATE_TIME = 4'd13;
  localparam logic [3:0] KEY_ADJ_UP    = 4'd14;
  localparam logic [3:0] KEY_ADJ_DOWN  = 4'd15;

  // A frame with two or more keys down carries no usable code, so it is
  // reported as MULTI and treated like an empty frame by the debouncer.
  function automatic frame_class_t classify_frame(input logic [ROWS*COLS-1:0] map);
    frame_class_t res;
    int           hits;
    res.kind = FRAME_NONE;
    res.code = '0;
    hits     = 0;
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (map[i]) begin
        hits++;
        res.code = 4'(i);
      end
    end
    if (hits == 1) begin
      res.kind = FRAME_ONE;
    end else if (hits > 1) begin
      res.kind = FRAME_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/matrix_key_scan_if.sv
// matrix_key_scan_if
//   Key matrix and key-event bundle.
//   col_in    : matrix columns, active-low, asynchronous to clk
//   row_out   : one-hot active-low row drive
//   key_code  : last accepted key (row*4 + col)
//   key_valid : one-cycle strobe on an accepted press
//   key_held  : high from accepted press until accepted release
//   master = the scanner, slave = matrix/consumer side.
interface matrix_key_scan_if;
  import matrix_key_scan_pkg::*;

  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_held;

  modport master (input col_in, output row_out, key_code, key_valid, key_held);
  modport slave  (output col_in, input row_out, key_code, key_valid, key_held);
endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
//   Enable-pulse divider: counts 0..DIV-1 and raises tick for the single
//   cycle in which the count sits at DIV-1. No derived clock is produced.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle enable pulse every DIV cycles
module scan_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int         W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q;

  assign tick = (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_key_scan.sv
// matrix_key_scan
//   Scans a 4x4 key matrix one row per SCAN_DIV cycles, assembles a 16-bit
//   frame map, and debounces a single pressed key over DEBOUNCE_CNT
//   identical frames before reporting its code with a one-cycle strobe.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kp    : key matrix / key event bundle (master side)
module matrix_key_scan
  import matrix_key_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  matrix_key_scan_if.master   kp
);

  localparam int              CW        = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [1:0]      LAST_ROW  = 2'(ROWS - 1);

  logic [COLS-1:0]      col_meta, col_sync;
  logic                 tick, frame_end;
  logic [1:0]           row_idx;
  logic [ROWS*COLS-1:0] frame_q, frame_now;
  frame_class_t         fc;

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d, code_q, code_d;
  logic          held_q, held_d, valid_q, accept;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= kp.col_in;
      col_sync <= col_meta;
    end
  end

  // The row being sampled on a tick is merged in combinationally so that
  // the frame-end decision already sees row 3 of the current frame.
  always_comb begin
    frame_now = frame_q;
    frame_now[{row_idx, 2'b00} +: COLS] = ~col_sync;
  end

  assign frame_end = tick && (row_idx == LAST_ROW);
  assign fc        = classify_frame(frame_now);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx <= '0;
      frame_q <= '0;
    end else if (tick) begin
      row_idx <= row_idx + 2'd1;
      frame_q <= frame_now;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    held_d  = held_q;
    accept  = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (fc.kind == FRAME_ONE) begin
            cand_d = fc.code;
            cnt_d  = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              accept  = 1'b1;
              state_d = PRESSED;
            end else begin
              state_d = DB_PRESS;
            end
          end
        end
        DB_PRESS: begin
          if (fc.kind == FRAME_ONE && fc.code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              accept  = 1'b1;
              state_d = PRESSED;
            end
          end else if (fc.kind == FRAME_ONE) begin
            cand_d = fc.code;
            cnt_d  = CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (!(fc.kind == FRAME_ONE && fc.code == code_q)) begin
            cnt_d = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              held_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = DB_REL;
            end
          end
        end
        DB_REL: begin
          // Any frame that again shows the held key is a release bounce.
          if (fc.kind == FRAME_ONE && fc.code == code_q) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              held_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept) begin
      code_d = cand_d;
      held_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      held_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      held_q  <= held_d;
      valid_q <= accept;
    end
  end

  assign kp.row_out   = ~(4'b0001 << row_idx);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// tb_matrix_key_scan
//   Directed bench for matrix_key_scan with SCAN_DIV=4, DEBOUNCE_CNT=3
//   (frame = 16 clk). A behavioural keypad pulls columns low for pressed
//   keys on the driven row; key sets change right after frame boundaries.
module tb_matrix_key_scan;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys  = '0;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  matrix_key_scan_if kif ();

  matrix_key_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its column to the currently driven row
  always_comb begin
    kif.col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kif.row_out[r] && keys[r*4 + c]) begin
          kif.col_in[c] = 1'b0;
        end
      end
    end
  end

  // Count every cycle in which key_valid is high
  always @(posedge clk) begin
    if (kif.key_valid === 1'b1) begin
      pulses++;
    end
  end

  // Waits for n frame boundaries (row_out 0111 -> 1110), bounded per frame
  task automatic wait_frames(input int n);
    logic [3:0] prev;
    bit         seen;
    for (int f = 0; f < n; f++) begin
      prev = kif.row_out;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (prev === 4'b0111 && kif.row_out === 4'b1110) seen = 1'b1;
        prev = kif.row_out;
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("[TB] FAIL frame_timeout: got no boundary in 40 cycles, required one");
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    checks++; if (kif.row_out !== 4'b1110) begin failures++; $display("[TB] FAIL reset_row: got %b expected 1110", kif.row_out); end
    checks++; if (kif.key_code !== 4'd0) begin failures++; $display("[TB] FAIL reset_code: got %0d expected 0", kif.key_code); end
    checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", kif.key_valid); end
    checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL reset_held: got %b expected 0", kif.key_held); end
  endtask

  task automatic test_row_rotation();
    logic [3:0] exp;
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      exp = ~(4'b0001 << ((k / 4) % 4));
      checks++; if (kif.row_out !== exp) begin failures++; $display("[TB] FAIL row_rotate k=%0d: got %b expected %b", k, kif.row_out, exp); end
    end
  endtask

  task automatic test_clean_press();
    int base;
    wait_frames(1);
    base = pulses;
    keys = 16'h0040;
    wait_frames(2);
    checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL press_early: got %b expected 0", kif.key_valid); end
    wait_frames(1);
    checks++; if (kif.key_valid !== 1'b1) begin failures++; $display("[TB] FAIL press_valid: got %b expected 1", kif.key_valid); end
    checks++; if (kif.key_code !== 4'd6) begin failures++; $display("[TB] FAIL press_code: got %0d expected 6", kif.key_code); end
    checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL press_held: got %b expected 1", kif.key_held); end
    @(negedge clk);
    checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL press_pulse_width: got %b expected 0", kif.key_valid); end
    checks++; if (pulses - base !== 1) begin failures++; $display("[TB] FAIL press_pulse_count: got %0d expected 1", pulses - base); end
    wait_frames(1);
    keys = '0;
    wait_frames(2);
    checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL release_early: got %b expected 1", kif.key_held); end
    wait_frames(1);
    checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL release_held: got %b expected 0", kif.key_held); end
    @(negedge clk);
    checks++; if (pulses - base !== 1) begin failures++; $display("[TB] FAIL release_pulse: got %0d expected 1", pulses - base); end
  endtask

  task automatic test_bounce();
    int base;
    base = pulses;
    keys = 16'h0040;
    wait_frames(2);
    keys = '0;
    wait_frames(1);
    keys = 16'h0040;
    wait_frames(2);
    checks++; if (pulses - base !== 0 || kif.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL bounce_early: got pulses=%0d valid=%b expected 0/0", pulses - base, kif.key_valid); end
    wait_frames(1);
    checks++; if (kif.key_valid !== 1'b1) begin failures++; $display("[TB] FAIL bounce_valid: got %b expected 1", kif.key_valid); end
    checks++; if (kif.key_code !== 4'd6) begin failures++; $display("[TB] FAIL bounce_code: got %0d expected 6", kif.key_code); end
    wait_frames(1);
    keys = '0;
    wait_frames(1);
    keys = 16'h0040;
    wait_frames(1);
    checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL rel_bounce_held: got %b expected 1", kif.key_held); end
    keys = '0;
    wait_frames(2);
    checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL rel_bounce_count: got %b expected 1", kif.key_held); end
    wait_frames(1);
    checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL bounce_release: got %b expected 0", kif.key_held); end
    checks++; if (pulses - base !== 1) begin failures++; $display("[TB] FAIL bounce_pulses: got %0d expected 1", pulses - base); end
  endtask

  task automatic test_multi_key();
    int base;
    base = pulses;
    keys = 16'h8001;
    wait_frames(4);
    checks++; if (kif.key_held !== 1'b0 || pulses - base !== 0) begin failures++; $display("[TB] FAIL multi_ignored: got held=%b pulses=%0d expected 0/0", kif.key_held, pulses - base); end
    keys = 16'h0001;
    wait_frames(2);
    checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL multi_early: got %b expected 0", kif.key_valid); end
    wait_frames(1);
    checks++; if (kif.key_valid !== 1'b1) begin failures++; $display("[TB] FAIL multi_valid: got %b expected 1", kif.key_valid); end
    checks++; if (kif.key_code !== 4'd0) begin failures++; $display("[TB] FAIL multi_code: got %0d expected 0", kif.key_code); end
    wait_frames(1);
    keys = '0;
    wait_frames(3);
    checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL multi_release: got %b expected 0", kif.key_held); end
    checks++; if (pulses - base !== 1) begin failures++; $display("[TB] FAIL multi_pulses: got %0d expected 1", pulses - base); end
  endtask

  task automatic test_held_override();
    int base;
    base = pulses;
    keys = 16'h0040;
    wait_frames(3);
    checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd6) begin failures++; $display("[TB] FAIL override_first: got valid=%b code=%0d expected 1/6", kif.key_valid, kif.key_code); end
    wait_frames(1);
    keys = 16'h0240;
    wait_frames(4);
    checks++; if (pulses - base !== 1) begin failures++; $display("[TB] FAIL override_ignored: got %0d expected 1", pulses - base); end
    keys = '0;
    wait_frames(3);
    checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL override_release: got %b expected 0", kif.key_held); end
    keys = 16'h0200;
    wait_frames(3);
    checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd9) begin failures++; $display("[TB] FAIL override_second: got valid=%b code=%0d expected 1/9", kif.key_valid, kif.key_code); end
    wait_frames(1);
    checks++; if (pulses - base !== 2) begin failures++; $display("[TB] FAIL override_pulses: got %0d expected 2", pulses - base); end
    keys = '0;
    wait_frames(3);
    checks++; if (kif.key_held !== 1'b0 || kif.key_code !== 4'd9) begin failures++; $display("[TB] FAIL override_hold_code: got held=%b code=%0d expected 0/9", kif.key_held, kif.key_code); end
  endtask

  task automatic test_async_reset();
    int base;
    keys = 16'h0020;
    wait_frames(2);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (kif.row_out !== 4'b1110) begin failures++; $display("[TB] FAIL areset_row: got %b expected 1110", kif.row_out); end
    checks++; if (kif.key_code !== 4'd0 || kif.key_held !== 1'b0 || kif.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_outputs: got code=%0d held=%b valid=%b expected 0/0/0", kif.key_code, kif.key_held, kif.key_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = pulses;
    wait_frames(2);
    checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_early: got %b expected 0", kif.key_valid); end
    wait_frames(1);
    checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd5 || kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL areset_repress: got valid=%b code=%0d held=%b expected 1/5/1", kif.key_valid, kif.key_code, kif.key_held); end
    wait_frames(2);
    checks++; if (pulses - base !== 1) begin failures++; $display("[TB] FAIL areset_pulses: got %0d expected 1", pulses - base); end
  endtask

  initial begin
    test_reset();
    test_row_rotation();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_held_override();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
